// File: rtl/i2s_pkg.sv
// i2s_mic_tx shared types and constants.
// State enum, parameter defaults and fill LFSR definition.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_t;

  localparam int DW_DEF     = 24;
  localparam int SLOT_W_DEF = 32;
  localparam int SYNC_DEF   = 2;

  localparam int          LFSR_W    = 24;
  // taps x^24 x^23 x^22 x^17
  localparam logic [23:0] LFSR_POLY = 24'hE10000;
  localparam logic [23:0] LFSR_SEED = 24'h000001;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    return {s[LFSR_W-2:0], ^(s & LFSR_POLY)};
  endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// Multi-flop synchronizer for an asynchronous I2S line
// with single-clk rise/fall pulses of the synchronized value.
import i2s_pkg::*;

module i2s_edge_sync #(
  parameter int STAGES = SYNC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_s    = r_sync[STAGES-1];
  assign o_rise = o_s & ~r_prev;
  assign o_fall = ~o_s & r_prev;

endmodule

// File: rtl/i2s_mic_tx.sv
// I2S slave transmitter emulating a stereo MEMS mic pair.
// Define I2S_MIC_TX_LFSR_EN for LFSR underflow fill (else zero).
import i2s_pkg::*;

module i2s_mic_tx #(
  parameter int DW          = DW_DEF,
  parameter int SLOT_W      = SLOT_W_DEF,
  parameter int SYNC_STAGES = SYNC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i2s_sck,
  input  logic          i2s_ws,
  output logic          i2s_sd,
  input  logic [DW-1:0] smp_l,
  input  logic [DW-1:0] smp_r,
  input  logic          smp_valid,
  output logic          smp_ready,
  output logic          underflow,
  output logic          underflow_sticky
);

  localparam int             CW      = $clog2(SLOT_W);
  localparam logic [CW-1:0]  CNT_MAX = '1;

  logic w_sck_s, w_sck_rise, w_sck_fall;
  logic w_ws_s, w_ws_rise, w_ws_fall;
  logic w_unused;

  i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (i2s_sck),
    .o_s    (w_sck_s),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_ws_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (i2s_ws),
    .o_s    (w_ws_s),
    .o_rise (w_ws_rise),
    .o_fall (w_ws_fall)
  );

  assign w_unused = ^{w_sck_s, w_sck_rise, w_ws_rise, w_ws_fall};

  i2s_state_t     r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_sd;
  logic           r_ws_last;
  logic           r_ready;
  logic           r_sticky;
  logic [DW-1:0]  r_smp_l;
  logic [DW-1:0]  r_smp_r;

  logic           w_bnd;
  logic           w_lbnd;
  logic           w_unf;
  logic [CW-1:0]  w_cnt_nxt;
  logic [DW-1:0]  w_active;
  logic [DW-1:0]  w_sh;
  logic [31:0]    w_k;
  logic           w_bit;
  logic [DW-1:0]  w_fill_l;
  logic [DW-1:0]  w_fill_r;

  // boundary is judged against WS seen at the previous SCK fall
  assign w_bnd  = w_sck_fall & (w_ws_s ^ r_ws_last);
  assign w_lbnd = w_bnd & ~w_ws_s;
  assign w_unf  = r_ready & ~smp_valid;

  assign w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_active  = (r_state == RIGHT) ? r_smp_r : r_smp_l;
  assign w_k       = 32'(w_cnt_nxt);
  assign w_sh      = w_active >> (32'(DW) - w_k);
  assign w_bit     = (w_k != 32'd0) && (w_k <= 32'(DW)) && w_sh[0];

`ifdef I2S_MIC_TX_LFSR_EN
  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_lfsr_nxt;

  assign w_lfsr_nxt = lfsr_next(r_lfsr);
  assign w_fill_l   = DW'(w_lfsr_nxt);
  assign w_fill_r   = ~w_fill_l;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_unf) begin
      r_lfsr <= w_lfsr_nxt;
    end
  end
`else
  assign w_fill_l = '0;
  assign w_fill_r = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sd      <= 1'b0;
      r_ws_last <= 1'b0;
      r_ready   <= 1'b0;
      r_sticky  <= 1'b0;
      r_smp_l   <= '0;
      r_smp_r   <= '0;
    end else begin
      r_ready <= 1'b0;
      if (r_ready) begin
        if (smp_valid) begin
          r_smp_l <= smp_l;
          r_smp_r <= smp_r;
        end else begin
          r_smp_l  <= w_fill_l;
          r_smp_r  <= w_fill_r;
          r_sticky <= 1'b1;
        end
      end
      if (w_sck_fall) begin
        r_ws_last <= w_ws_s;
        unique case (r_state)
          IDLE: begin
            r_sd  <= 1'b0;
            r_cnt <= '0;
            if (w_lbnd) begin
              r_state <= LEFT;
              r_ready <= 1'b1;
            end
          end
          LEFT, RIGHT: begin
            if (w_bnd) begin
              r_cnt   <= '0;
              r_sd    <= 1'b0;
              r_state <= w_ws_s ? RIGHT : LEFT;
              r_ready <= ~w_ws_s;
            end else begin
              r_cnt <= w_cnt_nxt;
              r_sd  <= w_bit;
            end
          end
          default: begin
            r_state <= IDLE;
            r_sd    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign i2s_sd           = r_sd;
  assign smp_ready        = r_ready;
  assign underflow        = w_unf;
  assign underflow_sticky = r_sticky;

endmodule

// File: tb/tb_i2s_mic_tx.sv
// Directed bench for i2s_mic_tx: I2S master/receiver model
// plus auto-advancing sample source.
module tb_i2s_mic_tx;

  logic        clk;
  logic        rst_n;
  logic        sck;
  logic        ws;
  logic        sd;
  logic [23:0] smp_l;
  logic [23:0] smp_r;
  logic        smp_valid;
  logic        smp_ready;
  logic        underflow;
  logic        sticky;

  int n_cmp;
  int n_bad;
  int n_rdy;
  int n_unf;
  int n_acc;
  int idx;

  logic [23:0] pl [9];
  logic [23:0] pr [9];
  logic [31:0] cl;
  logic [31:0] cr;
  logic [31:0] el;
  logic [31:0] er;

  i2s_mic_tx dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i2s_sck          (sck),
    .i2s_ws           (ws),
    .i2s_sd           (sd),
    .smp_l            (smp_l),
    .smp_r            (smp_r),
    .smp_valid        (smp_valid),
    .smp_ready        (smp_ready),
    .underflow        (underflow),
    .underflow_sticky (sticky)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // one slot of n SCK periods; receiver captures on SCK rise
  task automatic slot(
    input  logic        w,
    input  int          n,
    input  int          rel_idx,
    input  int          rst_idx,
    output logic [31:0] cap
  );
    cap = '0;
    for (int i = 0; i < n; i++) begin
      sck = 1'b0;
      if (i == 0) ws = w;
      if (i == rel_idx) rst_n = 1'b1;
      if (i == rst_idx) begin
        #20 rst_n = 1'b0;
        #60 rst_n = 1'b1;
        #20;
        chk("rst_sd", 32'(sd), 32'd0);
        chk("rst_sticky", 32'(sticky), 32'd0);
        #60;
      end else begin
        #160;
      end
      sck = 1'b1;
      cap = {cap[30:0], sd};
      #160;
    end
  endtask

  task automatic frame(
    input  int          nl,
    input  int          nr,
    output logic [31:0] capl,
    output logic [31:0] capr
  );
    slot(1'b0, nl, -1, -1, capl);
    slot(1'b1, nr, -1, -1, capr);
  endtask

  function automatic logic [31:0] word(input logic [23:0] s);
    return {1'b0, s, 7'd0};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (smp_ready) n_rdy++;
      if (underflow) n_unf++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (smp_ready && smp_valid) begin
        n_acc++;
        @(posedge clk);
        #1;
        if (idx < 8) idx++;
        smp_l = pl[idx];
        smp_r = pr[idx];
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    n_rdy = 0; n_unf = 0; n_acc = 0;
    idx = 0;
    pl[0] = 24'hA55AC3; pr[0] = 24'h123456;
    pl[1] = 24'h800001; pr[1] = 24'h7FFFFE;
    pl[2] = 24'h0F0F0F; pr[2] = 24'hF0F0F0;
    pl[3] = 24'h000001; pr[3] = 24'h800000;
    pl[4] = 24'hC0FFEE; pr[4] = 24'hBADA55;
    pl[5] = 24'hFFFFFF; pr[5] = 24'h654321;
    pl[6] = 24'h5A5A5A; pr[6] = 24'hC3C3C3;
    pl[7] = 24'h13579B; pr[7] = 24'h2468AC;
    pl[8] = 24'h000000; pr[8] = 24'h000000;
    rst_n = 1'b0;
    sck = 1'b1;
    ws = 1'b1;
    smp_valid = 1'b1;
    smp_l = pl[0];
    smp_r = pr[0];
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_sd0", 32'(sd), 32'd0);
    chk("rst_rdy0", 32'(smp_ready), 32'd0);
    chk("rst_unf0", 32'(underflow), 32'd0);
    chk("rst_stk0", 32'(sticky), 32'd0);

    slot(1'b1, 32, 12, -1, cr);
    chk("align_sd", cr, 32'd0);
    chk("align_rdy", 32'(n_rdy), 32'd0);

    frame(32, 32, cl, cr);
    chk("f0_l", cl, word(pl[0]));
    chk("f0_r", cr, word(pr[0]));
    chk("f0_rdy", 32'(n_rdy), 32'd1);
    chk("f0_idx", 32'(idx), 32'd1);

    for (int f = 1; f <= 4; f++) begin
      frame(32, 32, cl, cr);
      chk("bp_l", cl, word(pl[f]));
      chk("bp_r", cr, word(pr[f]));
    end
    chk("bp_rdy", 32'(n_rdy), 32'd5);
    chk("bp_acc", 32'(n_acc), 32'd5);
    chk("bp_idx", 32'(idx), 32'd5);

    frame(16, 32, cl, cr);
    chk("short_l", cl, 32'h0000_7FFF);
    chk("short_r", cr, word(pr[5]));
    chk("short_unf", 32'(n_unf), 32'd0);

    smp_valid = 1'b0;
    frame(32, 32, cl, cr);
    smp_valid = 1'b1;
`ifdef I2S_MIC_TX_LFSR_EN
    el = word(24'h000002);
    er = word(24'hFFFFFD);
`else
    el = 32'd0;
    er = 32'd0;
`endif
    chk("unf_l", cl, el);
    chk("unf_r", cr, er);
    chk("unf_cnt", 32'(n_unf), 32'd1);
    chk("unf_stk", 32'(sticky), 32'd1);
    chk("unf_idx", 32'(idx), 32'd6);

    slot(1'b0, 32, -1, 10, cl);
    el = {1'b0, pl[6][23:15], 22'd0};
    chk("mid_l", cl, el);
    slot(1'b1, 32, -1, -1, cr);
    chk("mid_r", cr, 32'd0);
    chk("mid_idx", 32'(idx), 32'd7);

    frame(32, 32, cl, cr);
    chk("rec_l", cl, word(pl[7]));
    chk("rec_r", cr, word(pr[7]));
    chk("end_rdy", 32'(n_rdy), 32'd9);
    chk("end_acc", 32'(n_acc), 32'd8);
    chk("end_unf", 32'(n_unf), 32'd1);
    chk("end_stk", 32'(sticky), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_mic_tx.md
Name: i2s_mic_tx

Overview:
- Synthesizable I2S slave transmitter that emulates one stereo pair of MEMS microphones.
- Drives the serial data line in response to the SCK and WS produced by the array's I2S receiver (PAD_CLK_MIC / PAD_WS).
- Serves as a loop-back / self-test source for the mic subsystem and as a drop-in bench driver replacing random-bit stimulus.
- Stereo sample pairs are loaded through a valid/ready handshake, one pair per WS frame.

Parameters:
- DW, 24: sample width in bits; requires 1 ≤ DW ≤ SLOT_W-1.
- SLOT_W, 32: nominal SCK periods per WS half-frame; used only for bit-counter sizing.
- SYNC_STAGES, 2: flip-flop stages in the SCK and WS synchronizers; minimum 2.

Ports:
- clk  in  1  system clock; must be ≥ 8× SCK frequency.
- rst_n  in  1  synchronous active-low reset.
- i2s_sck  in  1  bit clock from the receiver; asynchronous to clk.
- i2s_ws  in  1  word select from the receiver; 0 = left slot, 1 = right slot.
- i2s_sd  out  1  serial data to the receiver, MSB first.
- smp_l  in  DW  left sample, two's complement.
- smp_r  in  DW  right sample, two's complement.
- smp_valid  in  1  sample pair available.
- smp_ready  out  1  one-clk pulse offering acceptance at frame start.
- underflow  out  1  one-clk pulse when a frame starts with no valid pair.
- underflow_sticky  out  1  set by underflow; cleared only by reset.

Behaviour:
- Reset (rst_n=0 at a clk edge): i2s_sd=0, smp_ready=0, underflow=0, underflow_sticky=0; state=IDLE; bit_cnt=0; sample registers=0; synchronizer flops=0.
- SCK and WS each pass through SYNC_STAGES flops. An extra flop per signal provides edge detection.
- sck_fall: one-clk pulse when the synchronized SCK goes 1→0.
- Bit handling occurs only on sck_fall cycles. WS is read from its synchronized value in that same cycle.
- States:
  - IDLE: i2s_sd held at 0. On a sck_fall where ws_s=0 and ws_prev=1, go to LEFT.
  - LEFT: on a sck_fall with ws_s=1, go to RIGHT.
  - RIGHT: on a sck_fall with ws_s=0, go to LEFT.
  - Only IDLE requires an observed WS 1→0 transition. After any reset, no data is driven until the first full left slot.
- Slot boundary = a sck_fall on which ws_s differs from the ws value latched at the previous sck_fall.
  - On a boundary, bit_cnt←0 and i2s_sd←0. This is the one-bit I2S delay; the bit counts as padding of the old slot.
  - Otherwise bit_cnt←bit_cnt+1, saturating at 2^clog2(SLOT_W)-1.
  - Drive rule for k = bit_cnt after update: for 1 ≤ k ≤ DW, i2s_sd ← active_sample[DW-k]; for k > DW, i2s_sd ← 0.
  - active_sample is the left register in LEFT and the right register in RIGHT.
- i2s_sd changes exactly 1 clk after the sck_fall detection cycle. Total latency from a physical SCK falling edge is SYNC_STAGES+2 clk. This keeps the output stable at the receiver's next rising edge given the clk ≥ 8× SCK requirement.
- Handshake: smp_ready=1 for exactly the clk cycle of each left-slot boundary (WS 1→0). This includes the IDLE→LEFT transition.
  - If smp_valid=1 in that cycle, smp_l and smp_r are both latched and used for this frame's left and right slots.
  - If smp_valid=0: underflow pulses in that cycle, underflow_sticky←1, and both sample registers load the underflow fill value (see Optional Feature).
  - The right-slot boundary never accepts a sample.
- Short slot (WS toggles before DW bits are sent): the remaining bits are dropped and the next slot starts cleanly. This is not an error.
- Long slot (more SCKs than SLOT_W): padding zeros are driven and the counter saturates.
- Simultaneous WS and SCK edges are resolved by the shared synchronizer depth. WS is always evaluated with the same sck_fall.

Optional Feature:
- Macro: I2S_MIC_TX_LFSR_EN
- Defined: the underflow fill is the next state of an internal 24-bit Fibonacci LFSR.
  - Polynomial x^24+x^23+x^22+x^17+1, seed 24'h000001 at reset.
  - The LFSR advances once per underflow. The left register takes the LFSR's low DW bits; the right register takes the bitwise inverse of those bits.
- Undefined: the fill is all-zero and no LFSR logic exists.

Decomposition:
- Shared package i2s_pkg holds:
  - the state enum IDLE/LEFT/RIGHT;
  - the DW and SLOT_W defaults;
  - the LFSR polynomial and seed constants.
- Sub-module i2s_edge_sync (synchronizer plus rise/fall pulses) is instantiated twice, for SCK and for WS.

Test Plan:
- Normal frame: clk period 20 ns, SCK=clk/16, WS=SCK/64, smp_valid=1, L=24'hA55AC3, R=24'h123456 → a receiver model sampling SCK rising edges captures A55AC3 in left bits 1..24, 0 in bits 25..32, 123456 in the right slot; one smp_ready pulse per frame.
- Underflow: smp_valid=0 at a WS fall → underflow pulses for 1 clk, underflow_sticky=1, both slots read 0. With I2S_MIC_TX_LFSR_EN defined, L=24'h000002 and R=24'hFFFFFD.
- Reset alignment: release rst_n in the middle of a right slot → i2s_sd=0 and smp_ready=0 until the next WS fall, then the first frame is correct.
- Reset mid-frame: assert rst_n=0 for 3 clk during left bit 10 → i2s_sd=0 from the next clk, underflow_sticky cleared, normal output resumes at the next WS fall.
- Short slot: shrink the left slot to 16 SCKs with L=24'hFFFFFF → 15 ones are captured, then the right slot is delivered intact with no underflow.
- Back-pressure: hold smp_valid=1 across 4 frames with distinct pairs → exactly 4 pairs are consumed, one per WS fall, and none are duplicated or skipped.
